pwm_modulator: RTL

- Downstream consumer of the free-running period counter (count value plus terminal-count carry) in the digital modulation datapath.
- Accepts duty-cycle samples over a valid/ready handshake and buffers one sample ahead.
- Applies a new duty only on period boundaries and drives a glitch-free registered PWM output.
- Flags underrun when a period starts with no fresh sample.

---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_sample_buffer.sv | 39 +++
 rtl/pwm_modulator.sv | 103 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared types and width helper for the PWM modulator slice.
package pwm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

    // Width of count/duty values for a period of n clock cycles.
    function automatic int unsigned pwm_dw(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_sample_buffer.sv
// One-entry pending duty register with valid/ready intake, consume strobe and
// same-cycle bypass of an incoming sample when the entry is empty.
module pwm_sample_buffer #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic          consume,
    output logic          avail_c,
    output logic [DW-1:0] data_c
);

    logic          pend_valid;
    logic [DW-1:0] pend;
    logic          take_c;

    assign sample_ready = !pend_valid;
    assign take_c       = sample_valid && !pend_valid;

    // Held entry wins; otherwise a handshake this cycle is offered straight through.
    assign avail_c = pend_valid || take_c;
    assign data_c  = pend_valid ? pend : sample_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend       <= '0;
        end else if (consume && pend_valid) begin
            pend_valid <= 1'b0;
        end else if (take_c && !consume) begin
            pend_valid <= 1'b1;
            pend       <= sample_in;
        end
    end

endmodule

// File: rtl/pwm_modulator.sv
// Period-synchronous PWM generator: reloads duty from the sample buffer on the
// upstream counter's carry and drives a registered compare output.
module pwm_modulator
    import pwm_pkg::*;
#(
    parameter  int unsigned N  = 256,
    localparam int unsigned DW = pwm_dw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] cnt_in,
    input  logic          carry_in,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic          clr_underrun,
    output logic          pwm_out,
    output logic          period_start,
    output logic          underrun
);

    pwm_state_t    state_q, state_d;
    logic          load_c;
    logic          set_underrun_c;
    logic          avail_c;
    logic [DW-1:0] data_c;
    logic [DW-1:0] active_duty;
    logic          start_q;

    pwm_sample_buffer #(
        .DW (DW)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .consume      (load_c),
        .avail_c      (avail_c),
        .data_c       (data_c)
    );

    // Next-state and boundary decisions; carry_in marks the reload edge.
    always_comb begin
        state_d        = state_q;
        load_c         = 1'b0;
        set_underrun_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (carry_in && en && avail_c) begin
                    load_c  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (carry_in) begin
                    if (!en) begin
                        state_d = IDLE;
                    end else if (avail_c) begin
                        load_c = 1'b1;
                    end else begin
                        set_underrun_c = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Duty, compare output and flags. period_start is delayed one stage so it
    // lines up with the output cycle computed from cnt_in == 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_duty  <= '0;
            pwm_out      <= 1'b0;
            start_q      <= 1'b0;
            period_start <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (load_c) begin
                active_duty <= data_c;
            end
            pwm_out      <= (state_q == RUN) && (cnt_in < active_duty);
            start_q      <= (state_d == RUN) && carry_in;
            period_start <= start_q;
            if (set_underrun_c) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule
